// File: rtl/playback_sequencer.sv
// Note playback sequencer: walks a track's note ROM, holds each note for its
// encoded beat count and handles pause, next/previous track and stop keys.
module playback_sequencer #(
    parameter int unsigned TRACK_W = 2,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned NOTE_W  = 6,
    parameter int unsigned DUR_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      play_en_i,
    input  logic                      beat_tick_i,
    input  logic                      enter_i,
    input  logic                      arrow_up_i,
    input  logic                      arrow_down_i,
    input  logic                      esc_i,
    output logic [TRACK_W+IDX_W-1:0]  rom_addr_o,
    input  logic [NOTE_W+DUR_W-1:0]   rom_data_i,
    output logic [NOTE_W-1:0]         note_code_o,
    output logic                      note_valid_o,
    output logic                      paused_o,
    output logic [TRACK_W-1:0]        track_o,
    output logic                      track_done_o
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StHold, StPause} state_e;

    localparam logic [TRACK_W-1:0] TrackOne = TRACK_W'(1);
    localparam logic [IDX_W-1:0]   IdxOne   = IDX_W'(1);
    localparam logic [DUR_W-1:0]   BeatOne  = DUR_W'(1);

    state_e              state_q, state_d;
    logic [TRACK_W-1:0]  track_q, track_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DUR_W-1:0]    beat_q, beat_d;
    logic [NOTE_W-1:0]   code_q, code_d;
    logic                done_q, done_d;
    logic                end_of_track;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_note = rom_data_i[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data_i[DUR_W-1:0];

    // Next-state logic; key priority is stop > up > down > enter > beat_tick.
    always_comb begin
        state_d      = state_q;
        track_d      = track_q;
        idx_d        = idx_q;
        beat_d       = beat_q;
        code_d       = code_q;
        done_d       = 1'b0;
        end_of_track = 1'b0;

        if (!play_en_i || esc_i) begin
            state_d = StIdle;
            code_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    idx_d   = '0;
                    state_d = StFetch;
                end
                StFetch: state_d = StLoad;
                StLoad: begin
                    // A zero duration marks the end of the track.
                    if (rom_dur == '0) begin
                        end_of_track = 1'b1;
                    end else begin
                        code_d  = rom_note;
                        beat_d  = rom_dur;
                        state_d = StHold;
                    end
                end
                StHold, StPause: begin
                    if (arrow_up_i) begin
                        track_d = track_q + TrackOne;
                        idx_d   = '0;
                        state_d = StFetch;
                    end else if (arrow_down_i) begin
                        track_d = track_q - TrackOne;
                        idx_d   = '0;
                        state_d = StFetch;
                    end else if (enter_i) begin
                        state_d = (state_q == StHold) ? StPause : StHold;
                    end else if (beat_tick_i && state_q == StHold) begin
                        if (beat_q == BeatOne) begin
                            if (idx_q == '1) begin
                                end_of_track = 1'b1;
                            end else begin
                                idx_d   = idx_q + IdxOne;
                                state_d = StFetch;
                            end
                        end else begin
                            beat_d = beat_q - BeatOne;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (end_of_track) begin
                done_d  = 1'b1;
                track_d = track_q + TrackOne;
                idx_d   = '0;
                state_d = StFetch;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            track_q <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            track_q <= track_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr_o   = {track_q, idx_q};
    assign note_code_o  = code_q;
    assign note_valid_o = (state_q == StHold);
    assign paused_o     = (state_q == StPause);
    assign track_o      = track_q;
    assign track_done_o = done_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with a synchronous note ROM model.
module tb_playback_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       play_en, beat_tick, enter, arrow_up, arrow_down, esc;
    logic [7:0] rom_addr;
    logic [9:0] rom_data;
    logic [5:0] note_code;
    logic       note_valid, paused, track_done;
    logic [1:0] track;

    logic [9:0] rom [256];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0] in;   // {play_en, beat_tick, enter, arrow_up, arrow_down, esc}
        logic       nv;
        logic [5:0] code;
        logic       pa;
        logic [1:0] trk;
        logic       done;
        logic [7:0] addr;
    } vec_t;

    vec_t vq[$];

    playback_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .play_en_i    (play_en),
        .beat_tick_i  (beat_tick),
        .enter_i      (enter),
        .arrow_up_i   (arrow_up),
        .arrow_down_i (arrow_down),
        .esc_i        (esc),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .note_code_o  (note_code),
        .note_valid_o (note_valid),
        .paused_o     (paused),
        .track_o      (track),
        .track_done_o (track_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic nv, input logic [5:0] code,
                           input logic pa, input logic [1:0] trk, input logic done,
                           input logic [7:0] addr);
        chk({tag, ".note_valid"}, 32'(note_valid), 32'(nv));
        chk({tag, ".note_code"},  32'(note_code),  32'(code));
        chk({tag, ".paused"},     32'(paused),     32'(pa));
        chk({tag, ".track"},      32'(track),      32'(trk));
        chk({tag, ".track_done"}, 32'(track_done), 32'(done));
        chk({tag, ".rom_addr"},   32'(rom_addr),   32'(addr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] in);
        {play_en, beat_tick, enter, arrow_up, arrow_down, esc} = in;
    endtask

    task automatic add(input logic [5:0] in, input logic nv, input int code, input logic pa,
                       input int trk, input logic done, input int addr);
        vec_t v;
        v.in = in; v.nv = nv; v.code = 6'(code); v.pa = pa;
        v.trk = 2'(trk); v.done = done; v.addr = 8'(addr);
        vq.push_back(v);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = '0;
        rom[8'h00] = {6'd5, 4'd2};
        rom[8'h01] = {6'd9, 4'd1};
        rom[8'h02] = {6'd0, 4'd0};
        rom[8'h40] = {6'd7, 4'd3};
        rom[8'h41] = {6'd0, 4'd0};
        rom[8'h80] = {6'd11, 4'd1};
        rom[8'h81] = {6'd0, 4'd0};
        for (int i = 0; i < 64; i++) rom[8'hC0 + i] = {6'(63 - i), 4'd1};

        // inputs: pe bt en up dn esc | nv code pa trk done addr
        add(6'b000000, 0,  0, 0, 0, 0, 8'h00);  // idle
        add(6'b100000, 0,  0, 0, 0, 0, 8'h00);  // fetch
        add(6'b100000, 0,  0, 0, 0, 0, 8'h00);  // load
        add(6'b100000, 1,  5, 0, 0, 0, 8'h00);  // hold note 5
        add(6'b110000, 1,  5, 0, 0, 0, 8'h00);
        add(6'b110000, 0,  5, 0, 0, 0, 8'h01);  // note done
        add(6'b100000, 0,  5, 0, 0, 0, 8'h01);
        add(6'b100000, 1,  9, 0, 0, 0, 8'h01);  // hold note 9
        add(6'b110000, 0,  9, 0, 0, 0, 8'h02);
        add(6'b100000, 0,  9, 0, 0, 0, 8'h02);  // load marker
        add(6'b100000, 0,  9, 0, 1, 1, 8'h40);  // track_done pulse
        add(6'b100000, 0,  9, 0, 1, 0, 8'h40);
        add(6'b100000, 1,  7, 0, 1, 0, 8'h40);  // 3-beat note
        add(6'b110000, 1,  7, 0, 1, 0, 8'h40);
        add(6'b101000, 0,  7, 1, 1, 0, 8'h40);  // pause
        add(6'b110000, 0,  7, 1, 1, 0, 8'h40);
        add(6'b110000, 0,  7, 1, 1, 0, 8'h40);
        add(6'b110000, 0,  7, 1, 1, 0, 8'h40);
        add(6'b110000, 0,  7, 1, 1, 0, 8'h40);
        add(6'b101000, 1,  7, 0, 1, 0, 8'h40);  // resume
        add(6'b110000, 1,  7, 0, 1, 0, 8'h40);
        add(6'b110000, 0,  7, 0, 1, 0, 8'h41);  // second remaining tick ends it
        add(6'b100000, 0,  7, 0, 1, 0, 8'h41);
        add(6'b100000, 0,  7, 0, 2, 1, 8'h80);
        add(6'b100000, 0,  7, 0, 2, 0, 8'h80);
        add(6'b100000, 1, 11, 0, 2, 0, 8'h80);
        add(6'b100101, 0,  0, 0, 2, 0, 8'h80);  // esc beats arrow_up
        add(6'b100000, 0,  0, 0, 2, 0, 8'h80);
        add(6'b100000, 0,  0, 0, 2, 0, 8'h80);
        add(6'b100000, 1, 11, 0, 2, 0, 8'h80);
        add(6'b101100, 0, 11, 0, 3, 0, 8'hC0);  // up beats enter
        add(6'b100000, 0, 11, 0, 3, 0, 8'hC0);
        add(6'b100000, 1, 63, 0, 3, 0, 8'hC0);
        add(6'b100100, 0, 63, 0, 0, 0, 8'h00);  // up wraps 3 -> 0
        add(6'b100000, 0, 63, 0, 0, 0, 8'h00);
        add(6'b100000, 1,  5, 0, 0, 0, 8'h00);
        add(6'b100010, 0,  5, 0, 3, 0, 8'hC0);  // down wraps 0 -> 3
        add(6'b100000, 0,  5, 0, 3, 0, 8'hC0);
        add(6'b100000, 1, 63, 0, 3, 0, 8'hC0);
        add(6'b100100, 0, 63, 0, 0, 0, 8'h00);
        add(6'b100010, 0, 63, 0, 0, 0, 8'h00);  // down ignored in fetch
        add(6'b110000, 1,  5, 0, 0, 0, 8'h00);  // tick in load dropped
        add(6'b110000, 1,  5, 0, 0, 0, 8'h00);
        add(6'b110000, 0,  5, 0, 0, 0, 8'h01);
        add(6'b000000, 0,  0, 0, 0, 0, 8'h01);  // stop, index held
        add(6'b000000, 0,  0, 0, 0, 0, 8'h01);

        rst_n = 1'b0;
        drive(6'b000000);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < vq.size(); r++) begin
            drive(vq[r].in);
            step();
            chk_all($sformatf("vec%0d", r), vq[r].nv, vq[r].code, vq[r].pa, vq[r].trk,
                    vq[r].done, vq[r].addr);
        end

        // Index wrap: 64 one-beat notes on track 3 with no marker.
        drive(6'b100000);
        step(); step(); step();
        chk_all("wrap_start", 1, 5, 0, 0, 0, 8'h00);
        drive(6'b100010);
        step();
        drive(6'b100000);
        chk_all("wrap_down", 0, 5, 0, 3, 0, 8'hC0);
        for (int i = 0; i < 64; i++) begin
            step(); step();
            chk($sformatf("wrap%0d.valid", i), 32'(note_valid), 32'd1);
            chk($sformatf("wrap%0d.code", i), 32'(note_code), 32'(63 - i));
            drive(6'b110000);
            step();
            drive(6'b100000);
            if (i < 63) begin
                chk($sformatf("wrap%0d.addr", i), 32'(rom_addr), 32'(8'hC0 + i + 1));
                chk($sformatf("wrap%0d.done", i), 32'(track_done), 32'd0);
            end else begin
                chk_all("wrap_end", 0, 0, 0, 0, 1, 8'h00);
            end
        end

        // Asynchronous reset mid-note on track 1.
        step(); step();
        chk_all("pre_up", 1, 5, 0, 0, 0, 8'h00);
        drive(6'b100100);
        step();
        drive(6'b100000);
        step(); step();
        chk_all("pre_rst", 1, 7, 0, 1, 0, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("rst_fetch", 0, 0, 0, 0, 0, 8'h00);
        step(); step();
        chk_all("rst_hold", 1, 5, 0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Sequences note playback for the player's PLAYING mode. While the menu controller reports PLAYING, this block walks the selected track's note ROM, holds each note for its encoded number of beats, and drives the tone generator. It also handles pause/resume, next/previous track and stop from the debounced key pulses, and sits between the menu controller, the note ROM and the tone generator.

## Interface
- TRACK_W, 2: track select width; the number of tracks is 2^TRACK_W.
- IDX_W, 6: note index width within a track.
- NOTE_W, 6: note code width.
- DUR_W, 4: note duration field width, in beats.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- play_en  in  1  high while the menu state is PLAYING.
- beat_tick  in  1  one-cycle pulse at the beat rate.
- enter  in  1  one-cycle key pulse that toggles pause.
- arrow_up  in  1  one-cycle key pulse for next track.
- arrow_down  in  1  one-cycle key pulse for previous track.
- esc  in  1  one-cycle key pulse for stop.
- rom_addr  out  TRACK_W+IDX_W  {track, note_idx}; combinational from registers.
- rom_data  in  NOTE_W+DUR_W  {note_code, duration}; valid one cycle after rom_addr (synchronous ROM).
- note_code  out  NOTE_W  current note to the tone generator.
- note_valid  out  1  high only in HOLD.
- paused  out  1  high only in PAUSE.
- track  out  TRACK_W  current track.
- track_done  out  1  one-cycle pulse when the end of a track is reached.

## Operation
- States: IDLE, FETCH, LOAD, HOLD, PAUSE.
- IDLE: when play_en=1, clear note_idx and go to FETCH. track is retained.
- FETCH: rom_addr is presented. Go to LOAD.
- LOAD: capture rom_data.
  - duration==0 is the end-of-track marker: pulse track_done, set track=track+1 (mod 2^TRACK_W), set note_idx=0, go to FETCH.
  - Otherwise set note_code=rom_data[NOTE_W+DUR_W-1:DUR_W], set beat_cnt=duration, go to HOLD.
- HOLD: on beat_tick, if beat_cnt==1 the note is finished; else decrement beat_cnt.
  - Finished note with note_idx==2^IDX_W-1: treat as end of track (same actions as the marker case).
  - Finished note otherwise: note_idx+1, go to FETCH.
- HOLD with enter: go to PAUSE. beat_cnt, note_idx and note_code are frozen.
- PAUSE with enter: go back to HOLD. The remaining beats resume unchanged; beat_tick is ignored while in PAUSE.
- HOLD or PAUSE with arrow_up: track+1 (wraps 3->0), note_idx=0, paused cleared, go to FETCH.
- HOLD or PAUSE with arrow_down: track-1 (wraps 0->3), note_idx=0, go to FETCH.
- Any state with play_en=0 or esc: go to IDLE. note_code=0, note_valid=0, paused=0; track is retained.
- Priority when events coincide in the same cycle: (play_en=0 or esc) > arrow_up > arrow_down > enter > beat_tick. Only the highest-priority event takes effect.
- Key pulses in FETCH and LOAD are ignored, except esc and play_en=0, which always apply.
- beat_tick arriving in FETCH or LOAD is dropped, not queued.
- beat_cnt is DUR_W bits and never decrements below 1.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, track=0, note_idx=0, beat_cnt=0, note_code=0, note_valid=0, paused=0, track_done=0. Release is synchronous to clk.
- Start latency: play_en sampled high at edge k means FETCH after k, LOAD after k+1, and note_valid=1 after k+2.
- Note-to-note gap: the final beat_tick is sampled at edge m. note_valid is low after m and m+1, and the next note is valid after m+2.
- A note of duration D stays valid for D beat_ticks sampled in HOLD.
- track_done is high for exactly the cycle after the LOAD edge that detects the end of track.
- Stop latency: esc or play_en=0 sampled at edge k gives note_valid=0 and IDLE after k.
- Reset asserted mid-note: all outputs clear immediately, without waiting for clk.

## Test plan
- Start: ROM track 0 = {note 5, dur 2}, {note 9, dur 1}, {dur 0}. Raise play_en, then apply ticks. Required: note_code 5 valid for 2 ticks, then 9 for 1 tick, then a track_done pulse, then track=1 and rom_addr=0x40.
- Pause: enter during the 3-beat note after 1 tick, then 4 beat_ticks, then enter again. Required: paused=1 and note_valid=0 during the pause; after resume the note lasts exactly 2 more ticks.
- Track wrap: starting at track=3, arrow_up gives track=0 and note_idx=0. Starting at track=0, arrow_down gives track=3.
- Simultaneous events: esc and arrow_up in the same HOLD cycle give IDLE with track unchanged. arrow_up and enter together give next track with paused=0.
- Index wrap: a track with 64 entries of duration 1 and no marker. After the 64th tick: track_done, then track+1.
- Asynchronous reset: drop reset_n mid-HOLD between clock edges. Required: all outputs 0 and track=0 immediately; after release with play_en=1, playback restarts from rom_addr 0.
